// File: rtl/clock_rate_generator.sv
// Programmable-rate io clock generator with registered edge strobes, lock status
// and a rate-update handshake that only applies new rates on period boundaries.

package clks_alot_p;
    localparam int RATE_COUNTER_WIDTH = 8;

    typedef struct packed {
        logic rising_edge;
        logic falling_edge;
    } generated_events_s;
endpackage

module clock_rate_generator #(
    parameter int RATE_W = clks_alot_p::RATE_COUNTER_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clk_en_i,
    input  logic                           generation_en_i,
    input  logic [RATE_W-1:0]              high_rate_i,
    input  logic [RATE_W-1:0]              low_rate_i,
    input  logic                           rate_update_i,
    output logic                           rate_update_ack_o,
    output logic                           io_clk_o,
    output clks_alot_p::generated_events_s clk_events_o,
    output logic                           locked_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                stopping_q, stopping_d;
    logic [RATE_W-1:0]   hi_act_q, hi_act_d;
    logic [RATE_W-1:0]   lo_act_q, lo_act_d;
    logic [RATE_W-1:0]   hi_pend_q, hi_pend_d;
    logic [RATE_W-1:0]   lo_pend_q, lo_pend_d;
    logic                pend_q, pend_d;
    logic [RATE_W-1:0]   cnt_q, cnt_d;
    logic [1:0]          per_q, per_d;
    logic                io_clk_q, io_clk_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic                ack_q, ack_d;

    always_comb begin
        state_d    = state_q;
        stopping_d = stopping_q;
        hi_act_d   = hi_act_q;
        lo_act_d   = lo_act_q;
        hi_pend_d  = hi_pend_q;
        lo_pend_d  = lo_pend_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        per_d      = per_q;
        io_clk_d   = io_clk_q;
        rise_d     = rise_q;
        fall_d     = fall_q;
        ack_d      = ack_q;

        if (clk_en_i) begin
            ack_d = rate_update_i;

            case (state_q)
                IDLE: begin
                    stopping_d = 1'b0;
                    cnt_d      = '0;
                    per_d      = 2'd0;
                    if (pend_q) begin
                        hi_act_d = hi_pend_q;
                        lo_act_d = lo_pend_q;
                        pend_d   = 1'b0;
                    end
                    if (generation_en_i) begin
                        state_d = HIGH;
                    end
                end

                HIGH: begin
                    if (!generation_en_i) begin
                        stopping_d = 1'b1;
                    end
                    if (cnt_q == hi_act_q) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + RATE_W'(1);
                    end
                end

                LOW: begin
                    if (!generation_en_i) begin
                        stopping_d = 1'b1;
                    end
                    if (cnt_q == lo_act_q) begin
                        // Period boundary: the only place a running clock may stop or change rate.
                        cnt_d = '0;
                        if (stopping_q || !generation_en_i) begin
                            state_d    = IDLE;
                            per_d      = 2'd0;
                            stopping_d = 1'b0;
                        end else begin
                            state_d = HIGH;
                            if (pend_q) begin
                                hi_act_d = hi_pend_q;
                                lo_act_d = lo_pend_q;
                                pend_d   = 1'b0;
                                per_d    = 2'd0;
                            end else if (per_q != 2'd2) begin
                                per_d = per_q + 2'd1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + RATE_W'(1);
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase

            // A request on an applying cycle wins over the pend clear, so it waits for the next boundary.
            if (rate_update_i) begin
                hi_pend_d = high_rate_i;
                lo_pend_d = low_rate_i;
                pend_d    = 1'b1;
            end

            io_clk_d = (state_d == HIGH);
            rise_d   = (state_d == HIGH) && (state_q != HIGH);
            fall_d   = (state_q == HIGH) && (state_d != HIGH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            stopping_q <= 1'b0;
            hi_act_q   <= '0;
            lo_act_q   <= '0;
            hi_pend_q  <= '0;
            lo_pend_q  <= '0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            per_q      <= 2'd0;
            io_clk_q   <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stopping_q <= stopping_d;
            hi_act_q   <= hi_act_d;
            lo_act_q   <= lo_act_d;
            hi_pend_q  <= hi_pend_d;
            lo_pend_q  <= lo_pend_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            per_q      <= per_d;
            io_clk_q   <= io_clk_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            ack_q      <= ack_d;
        end
    end

    assign io_clk_o                  = io_clk_q;
    assign clk_events_o.rising_edge  = rise_q;
    assign clk_events_o.falling_edge = fall_q;
    assign rate_update_ack_o         = ack_q;
    assign locked_o                  = (per_q == 2'd2) && (state_q != IDLE) && !stopping_q;

endmodule

// File: tb/tb_clock_rate_generator.sv
// Directed scoreboard bench for clock_rate_generator: expected io/rise/fall/lock/ack
// words are queued as each cycle is driven and checked on the following falling edge.

module tb_clock_rate_generator;

    localparam int W = clks_alot_p::RATE_COUNTER_WIDTH;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic                           clk_en;
    logic                           gen_en;
    logic [W-1:0]                   hi;
    logic [W-1:0]                   lo;
    logic                           upd;
    logic                           ack;
    logic                           io_clk;
    logic                           locked;
    clks_alot_p::generated_events_s ev;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [4:0] v;
    } exp_t;

    exp_t sb[$];

    clock_rate_generator #(.RATE_W(W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .clk_en_i          (clk_en),
        .generation_en_i   (gen_en),
        .high_rate_i       (hi),
        .low_rate_i        (lo),
        .rate_update_i     (upd),
        .rate_update_ack_o (ack),
        .io_clk_o          (io_clk),
        .clk_events_o      (ev),
        .locked_o          (locked)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] pack(input logic io, input logic ri, input logic fa,
                                        input logic lk, input logic ak);
        return {io, ri, fa, lk, ak};
    endfunction

    task automatic push(input string tag, input logic [4:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t       e;
        logic [4:0] obs;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: observed no entry required one");
        end else begin
            e   = sb.pop_front();
            obs = {io_clk, ev.rising_edge, ev.falling_edge, locked, ack};
            assert (obs === e.v) else begin
                bad++;
                $error("FAIL %s: io/rise/fall/lock/ack observed=%b expected=%b", e.tag, obs, e.v);
            end
            $display("t=%0t %s io/rise/fall/lock/ack=%b", $time, e.tag, obs);
        end
    endtask

    task automatic step(input string tag, input logic [4:0] v);
        push(tag, v);
        @(posedge clk);
        @(negedge clk);
        check_pop();
    endtask

    task automatic one(input string tag, input logic [4:0] v, input bit gap);
        step(tag, v);
        if (gap) begin
            clk_en = 1'b0;
            step({tag, "_hold"}, v);
            clk_en = 1'b1;
        end
    endtask

    // Expected waveform of nper full periods; k0 is the count of periods already run at these rates.
    task automatic run_gen(input string tag, input int h, input int l, input int nper,
                           input int k0, input bit gap);
        logic lk;
        for (int p = 0; p < nper; p++) begin
            lk = ((k0 + p) >= 2);
            for (int c = 0; c <= h; c++) one(tag, pack(1'b1, c == 0, 1'b0, lk, 1'b0), gap);
            for (int c = 0; c <= l; c++) one(tag, pack(1'b0, 1'b0, c == 0, lk, 1'b0), gap);
        end
    endtask

    task automatic load(input int hr, input int lr);
        hi  = W'(hr);
        lo  = W'(lr);
        upd = 1'b1;
        step("load_ack", pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        upd = 1'b0;
        step("load_idle", 5'b0);
    endtask

    task automatic stop(input string tag);
        gen_en = 1'b0;
        step(tag, 5'b0);
    endtask

    initial begin
        rst_n  = 1'b0;
        clk_en = 1'b1;
        gen_en = 1'b0;
        hi     = '0;
        lo     = '0;
        upd    = 1'b0;
        #1;
        push("reset", 5'b0);
        check_pop();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // hi=2 lo=1: period 5, rising at 1,6,11,16, lock from cycle 11
        load(2, 1);
        gen_en = 1'b1;
        run_gen("t1_hi2_lo1", 2, 1, 4, 0, 1'b0);
        stop("t1_stop");

        // 0/0 toggles every enabled cycle
        load(0, 0);
        gen_en = 1'b1;
        run_gen("t2_rate00", 0, 0, 4, 0, 1'b0);
        stop("t2_stop");

        // running 3/3, update to 1/1 on the 2nd HIGH cycle of a locked period
        load(3, 3);
        gen_en = 1'b1;
        run_gen("t3_old", 3, 3, 3, 0, 1'b0);
        step("t3_h0", pack(1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        hi  = W'(1);
        lo  = W'(1);
        upd = 1'b1;
        step("t3_h1_ack", pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        upd = 1'b0;
        for (int c = 2; c <= 3; c++) step("t3_h_old", pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        step("t3_l0_old", pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        for (int c = 1; c <= 3; c++) step("t3_l_old", pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        run_gen("t3_new", 1, 1, 3, 0, 1'b0);
        stop("t3_stop");

        // disable on 2nd HIGH cycle; re-enable mid-LOW still passes through IDLE
        load(3, 3);
        gen_en = 1'b1;
        run_gen("t4_run", 3, 3, 3, 0, 1'b0);
        step("t4_h0", pack(1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        step("t4_h1", pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        gen_en = 1'b0;
        step("t4_h2_unlock", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        step("t4_h3", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        step("t4_l0", pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        step("t4_l1", 5'b0);
        gen_en = 1'b1;
        step("t4_l2", 5'b0);
        step("t4_l3", 5'b0);
        step("t4_idle_pass", 5'b0);
        run_gen("t4_restart", 3, 3, 1, 0, 1'b0);
        stop("t4_stop");

        // clk_en 1,0,1,0 with 1/1: phases count enabled cycles, strobes hold
        load(1, 1);
        gen_en = 1'b1;
        run_gen("t5_gap", 1, 1, 3, 0, 1'b1);
        stop("t5_stop");

        // async reset mid-LOW with a pending update
        load(2, 2);
        gen_en = 1'b1;
        run_gen("t6_run", 2, 2, 2, 0, 1'b0);
        step("t6_h0", pack(1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        hi  = W'(5);
        lo  = W'(5);
        upd = 1'b1;
        step("t6_h1_ack", pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        upd = 1'b0;
        step("t6_h2", pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        step("t6_l0", pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        push("t6_async_reset", 5'b0);
        check_pop();
        @(negedge clk);
        push("t6_reset_held", 5'b0);
        check_pop();
        rst_n = 1'b1;
        run_gen("t6_after_reset", 0, 0, 3, 0, 1'b0);
        stop("t6_stop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
